// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request/response and ALU drive bundle for alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
    logic               req0_valid;
    logic               req0_ready;
    logic signed [31:0] req0_op1;
    logic signed [31:0] req0_op2;
    logic        [5:0]  req0_func;
    logic               req1_valid;
    logic               req1_ready;
    logic signed [31:0] req1_op1;
    logic signed [31:0] req1_op2;
    logic        [5:0]  req1_func;
    logic               resp0_valid;
    logic               resp0_ready;
    logic               resp1_valid;
    logic               resp1_ready;
    logic signed [31:0] resp_result;
    logic        [3:0]  resp_flags;
    logic signed [31:0] alu_op1;
    logic signed [31:0] alu_op2;
    logic        [5:0]  alu_func;
    logic signed [31:0] alu_result;
    logic               alu_overflow;
    logic               alu_equals;
    logic               alu_above;
    logic               alu_zero;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_func,
        input  req1_valid, req1_op1, req1_op2, req1_func,
        input  resp0_ready, resp1_ready,
        input  alu_result, alu_overflow, alu_equals, alu_above, alu_zero,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_result, resp_flags, alu_op1, alu_op2, alu_func
    );

    // Requesters and ALU side
    modport master (
        output req0_valid, req0_op1, req0_op2, req0_func,
        output req1_valid, req1_op1, req1_op2, req1_func,
        output resp0_ready, resp1_ready,
        output alu_result, alu_overflow, alu_equals, alu_above, alu_zero,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_result, resp_flags, alu_op1, alu_op2, alu_func
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester arbiter sharing one combinational ALU, with a
//            settle delay and valid/ready response. Define
//            ALU_ARB_FIXED_PRIORITY_EN for fixed priority to requester 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter logic [5:0]  IDLE_FUNC   = 6'b000000
) (
    input  wire logic    clock,
    input  wire logic    reset,
    alu_arbiter_if.slave bus,
    output logic         busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;
    localparam logic [3:0] c_wait_load = 4'(ALU_LATENCY - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic               r_owner;
    logic               r_last_grant;
    logic [5:0]         r_func;
    logic signed [31:0] r_op1;
    logic signed [31:0] r_op2;
    logic signed [31:0] r_result;
    logic [3:0]         r_flags;

    logic w_any_valid;
    logic w_grant;
    logic w_accept;
    logic w_cnt_zero;
    logic w_owner_ready;

    assign w_any_valid   = bus.req0_valid | bus.req1_valid;
    assign w_accept      = (r_state == c_st_idle) & ~reset & w_any_valid;
    assign w_cnt_zero    = (r_cnt == 4'd0);
    assign w_owner_ready = r_owner ? bus.resp1_ready : bus.resp0_ready;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    assign w_grant = bus.req1_valid & ~bus.req0_valid;
`else
    // Under contention the requester not served last time wins
    assign w_grant = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        bus.alu_func    = IDLE_FUNC;
        busy            = (r_state != c_st_idle);
        case (r_state)
            c_st_idle: begin
                bus.req0_ready = w_accept & ~w_grant;
                bus.req1_ready = w_accept & w_grant;
                if (w_any_valid) begin
                    w_next_state = c_st_issue;
                end
            end
            c_st_issue: begin
                bus.alu_func = r_func;
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                bus.alu_func = r_func;
                if (w_cnt_zero) begin
                    w_next_state = c_st_resp;
                end
            end
            c_st_resp: begin
                bus.resp0_valid = ~r_owner;
                bus.resp1_valid = r_owner;
                if (w_owner_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_func       <= 6'd0;
            r_op1        <= 32'sd0;
            r_op2        <= 32'sd0;
            r_result     <= 32'sd0;
            r_flags      <= 4'd0;
        end else begin
            if (w_accept) begin
                r_op1        <= w_grant ? bus.req1_op1  : bus.req0_op1;
                r_op2        <= w_grant ? bus.req1_op2  : bus.req0_op2;
                r_func       <= w_grant ? bus.req1_func : bus.req0_func;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == c_st_issue) begin
                r_cnt <= c_wait_load;
            end else if ((r_state == c_st_wait) && !w_cnt_zero) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((r_state == c_st_wait) && w_cnt_zero) begin
                r_result <= bus.alu_result;
                r_flags  <= {bus.alu_overflow, bus.alu_equals, bus.alu_above, bus.alu_zero};
            end
        end
    end

    assign bus.alu_op1     = r_op1;
    assign bus.alu_op2     = r_op2;
    assign bus.resp_result = r_result;
    assign bus.resp_flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_MUL = 6'b011000;
    localparam logic [5:0] F_OR  = 6'b100101;

    typedef struct {
        bit          owner;
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    logic clock;
    logic reset;
    logic busy;
    alu_arbiter_if bus ();
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic signed [31:0] alu_r;

    alu_arbiter #(.ALU_LATENCY(1), .IDLE_FUNC(6'b000000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always_comb begin
        alu_r = 32'sd0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_func)
            F_ADD: begin
                alu_r = bus.alu_op1 + bus.alu_op2;
                bus.alu_overflow = (bus.alu_op1[31] == bus.alu_op2[31]) && (alu_r[31] != bus.alu_op1[31]);
            end
            F_SUB: begin
                alu_r = bus.alu_op1 - bus.alu_op2;
                bus.alu_overflow = (bus.alu_op1[31] != bus.alu_op2[31]) && (alu_r[31] != bus.alu_op1[31]);
            end
            F_MUL:   alu_r = bus.alu_op1 * bus.alu_op2;
            F_OR:    alu_r = bus.alu_op1 | bus.alu_op2;
            default: alu_r = 32'sd0;
        endcase
        bus.alu_result = alu_r;
        bus.alu_equals = (bus.alu_op1 == bus.alu_op2);
        bus.alu_above  = (bus.alu_op1 > bus.alu_op2);
        bus.alu_zero   = (alu_r == 32'sd0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every completed response handshake
    always @(negedge clock) begin
        if (bus.resp0_valid && bus.resp1_valid) chk("resp_both_valid", 1, 0);
        if (bus.resp0_valid || bus.resp1_valid) chk("func_idle_in_resp", {26'd0, bus.alu_func}, 0);
        if ((bus.resp0_valid && bus.resp0_ready) || (bus.resp1_valid && bus.resp1_ready)) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_owner", {31'd0, bus.resp1_valid}, {31'd0, e.owner});
                chk("resp_result", bus.resp_result, e.res);
                chk("resp_flags", {28'd0, bus.resp_flags}, {28'd0, e.flags});
            end
        end
    end

    task automatic send(input bit n, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] f, input bit exp_resp, input logic [31:0] er,
                        input logic [3:0] ef, output int waited);
        bit got;
        exp_t e;
        got = 0;
        waited = 0;
        if (n == 1'b0) begin
            bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_func = f; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_func = f; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if ((n == 1'b0 && bus.req0_ready) || (n == 1'b1 && bus.req1_ready)) begin
                got = 1;
                break;
            end
            waited++;
        end
        chk("grant_seen", {31'd0, got}, 1);
        if (got) begin
            chk("other_ready_low", {31'd0, (n ? bus.req0_ready : bus.req1_ready)}, 0);
            if (exp_resp) begin
                e.owner = n; e.res = er; e.flags = ef;
                sb.push_back(e);
            end
        end
        @(posedge clock); #1;
        if (n == 1'b0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        chk("idle_timeout", {31'd0, done}, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit found;
        bit e;
        exp_t x;
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op1 = 5; bus.req0_op2 = 7; bus.req0_func = F_ADD;
        bus.req1_valid = 1'b0; bus.req1_op1 = 0; bus.req1_op2 = 0; bus.req1_func = 6'd0;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;

        // Reset values, with a request pending
        @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 0);
        chk("rst_resp_valid", {30'd0, bus.resp0_valid, bus.resp1_valid}, 0);
        chk("rst_result", bus.resp_result, 0);
        chk("rst_flags", {28'd0, bus.resp_flags}, 0);
        chk("rst_alu_op1", bus.alu_op1, 0);
        chk("rst_alu_func", {26'd0, bus.alu_func}, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Single add: ready in cycle 0, func in cycle 1, response only in cycle 3
        send(0, 5, 7, F_ADD, 1, 12, 4'b0000, w);
        chk("t1_accept_cycle", w, 0);
        @(negedge clock);
        chk("t1_c1_func", {26'd0, bus.alu_func}, {26'd0, F_ADD});
        chk("t1_c1_busy", {31'd0, busy}, 1);
        chk("t1_c1_resp", {30'd0, bus.resp0_valid, bus.resp1_valid}, 0);
        @(negedge clock);
        chk("t1_c2_resp", {30'd0, bus.resp0_valid, bus.resp1_valid}, 0);
        chk("t1_c2_func", {26'd0, bus.alu_func}, {26'd0, F_ADD});
        @(negedge clock);
        chk("t1_c3_resp", {30'd0, bus.resp0_valid, bus.resp1_valid}, 2);
        @(negedge clock);
        chk("t1_c4_resp", {30'd0, bus.resp0_valid, bus.resp1_valid}, 0);
        chk("t1_c4_busy", {31'd0, busy}, 0);
        @(posedge clock); #1;

        // Contention at reset exit: req0 first, req1 right after RESP exit
        reset = 1'b1;
        bus.req1_op1 = 3; bus.req1_op2 = 4; bus.req1_func = F_MUL; bus.req1_valid = 1'b1;
        bus.req0_op1 = 9; bus.req0_op2 = 9; bus.req0_func = F_SUB; bus.req0_valid = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        send(0, 9, 9, F_SUB, 1, 0, 4'b0101, w);
        chk("t2_req0_first", w, 0);
        send(1, 3, 4, F_MUL, 1, 12, 4'b0000, w);
        chk("t2_req1_spacing", w, 3);
        wait_idle();

        // Second contention after req0 was last served
        send(0, 10, 3, F_SUB, 1, 7, 4'b0010, w);
        wait_idle();
        bus.req0_op1 = 100; bus.req0_op2 = 200; bus.req0_func = F_ADD; bus.req0_valid = 1'b1;
        bus.req1_op1 = 3; bus.req1_op2 = 10; bus.req1_func = F_SUB; bus.req1_valid = 1'b1;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        send(0, 100, 200, F_ADD, 1, 300, 4'b0000, w);
        chk("t2b_first", w, 0);
        send(1, 3, 10, F_SUB, 1, 32'hFFFF_FFF9, 4'b0000, w);
        chk("t2b_second", w, 3);
`else
        send(1, 3, 10, F_SUB, 1, 32'hFFFF_FFF9, 4'b0000, w);
        chk("t2b_first", w, 0);
        send(0, 100, 200, F_ADD, 1, 300, 4'b0000, w);
        chk("t2b_second", w, 3);
`endif
        wait_idle();

        // Response back-pressure on req1; req0 waits and its resp_ready is ignored
        bus.resp1_ready = 1'b0;
        send(1, 32'hF0, 32'h0F, F_OR, 1, 32'hFF, 4'b0010, w);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.resp1_valid) begin
                found = 1;
                break;
            end
        end
        chk("t3_resp1_seen", {31'd0, found}, 1);
        @(posedge clock); #1;
        bus.req0_op1 = 1; bus.req0_op2 = 1; bus.req0_func = F_ADD; bus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t3_hold_valid", {31'd0, bus.resp1_valid}, 1);
            chk("t3_hold_result", bus.resp_result, 32'hFF);
            chk("t3_req0_blocked", {31'd0, bus.req0_ready}, 0);
            chk("t3_resp0_low", {31'd0, bus.resp0_valid}, 0);
        end
        @(posedge clock); #1;
        bus.resp1_ready = 1'b1;

        // Back-to-back identical adds
        send(0, 1, 1, F_ADD, 1, 2, 4'b0100, w);
        send(0, 2, 2, F_ADD, 1, 4, 4'b0100, w);
        chk("t4_back_to_back", w, 3);
        wait_idle();

        // Reset during WAIT drops the transaction
        send(0, 7, 8, F_ADD, 0, 0, 4'b0000, w);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_result", bus.resp_result, 0);
        chk("t5_alu_op1", bus.alu_op1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t5_no_resp", {30'd0, bus.resp0_valid, bus.resp1_valid}, 0);
        end
        @(posedge clock); #1;
        send(1, 5, 5, F_SUB, 1, 0, 4'b0101, w);
        chk("t5_fresh_accept", w, 0);
        wait_idle();

        // Continuous contention: grant sequence and spacing
        bus.req0_op1 = 1;  bus.req0_op2 = 2;  bus.req0_func = F_ADD; bus.req0_valid = 1'b1;
        bus.req1_op1 = 10; bus.req1_op2 = 20; bus.req1_func = F_ADD; bus.req1_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.req0_ready || bus.req1_ready) begin
                found = 1;
                break;
            end
        end
        chk("t6_first_grant", {31'd0, found}, 1);
        for (int g = 0; g < 6; g++) begin
            if (g > 0) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    chk("t6_gap_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
                end
                @(negedge clock);
            end
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            e = 1'b0;
`else
            e = g[0];
`endif
            chk("t6_grant", {30'd0, bus.req1_ready, bus.req0_ready}, e ? 32'd2 : 32'd1);
            x.owner = e;
            x.res   = e ? 32'd30 : 32'd3;
            x.flags = 4'b0000;
            sb.push_back(x);
        end
        @(posedge clock); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_idle();

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
